// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler: double-buffered frame, dwell/gap timing, PWM dimming, masks.
// Optional blink feature enabled by defining SEG_BLINK_EN (adds blink_mask port and BLINK_FRAMES).
module seg_scan_ctrl #(
    parameter int unsigned DWELL_CYC    = 50000,
    parameter int unsigned GAP_CYC      = 500
`ifdef SEG_BLINK_EN
    ,parameter int unsigned BLINK_FRAMES = 250
`endif
) (
    input  logic        FPGA_CLK,
    input  logic        RESET_BUT,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_blank,
    input  logic [3:0]  brightness,
    input  logic        lz_blank_en,
    output logic [3:0]  data_seg,
    output logic [3:0]  en_seg,
    output logic        dt,
    output logic        frame_tick
`ifdef SEG_BLINK_EN
    ,input  logic [3:0] blink_mask
`endif
);

    localparam int unsigned SLICE_CYC = DWELL_CYC / 16;
    localparam int unsigned SW        = (SLICE_CYC > 1) ? $clog2(SLICE_CYC) : 1;
    localparam int unsigned GW        = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic {ST_GAP, ST_SCAN} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_digit;
    logic [3:0]    r_slice, r_duty;
    logic [SW-1:0] r_sub;
    logic [GW-1:0] r_gap;
    logic [15:0]   r_act_data, r_sh_data;
    logic [3:0]    r_act_dp, r_act_blank, r_sh_dp, r_sh_blank;
    logic          r_wr_ready, r_frame_tick, r_dt;
    logic [3:0]    r_en_seg, r_data_seg;

    logic          w_gap_done, w_slice_end, w_scan_done, w_commit, w_tick_nxt, w_xfer;
    logic          w_blink_off;
    logic [3:0]    w_lz, w_nibble, w_en_nxt, w_data_nxt;
    logic          w_dt_nxt;

    assign w_gap_done  = (r_state == ST_GAP) && (r_gap == GW'(GAP_CYC - 1));
    assign w_slice_end = (r_sub == SW'(SLICE_CYC - 1));
    assign w_scan_done = (r_state == ST_SCAN) && w_slice_end && (r_slice == 4'd15);
    assign w_commit    = w_scan_done && (r_digit == 2'd3);
    // frame_tick is registered, so it is raised one cycle ahead to coincide with the commit cycle
    assign w_tick_nxt  = (r_state == ST_SCAN) && (r_digit == 2'd3) && (r_slice == 4'd15)
                         && (r_sub == SW'(SLICE_CYC - 2));
    assign w_xfer      = wr_valid && r_wr_ready;

    assign w_lz[0]  = 1'b0;
    assign w_lz[1]  = lz_blank_en && (r_act_data[15:4]  == 12'd0);
    assign w_lz[2]  = lz_blank_en && (r_act_data[15:8]  == 8'd0);
    assign w_lz[3]  = lz_blank_en && (r_act_data[15:12] == 4'd0);
    assign w_nibble = r_act_data[{r_digit, 2'b00} +: 4];

`ifdef SEG_BLINK_EN
    localparam int unsigned BW = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    logic [BW-1:0] r_blink_cnt;

    // Frame counter; upper half of the period darkens masked digits
    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            r_blink_cnt <= '0;
        end else if (w_commit) begin
            r_blink_cnt <= (r_blink_cnt == BW'(2 * BLINK_FRAMES - 1)) ? '0 : r_blink_cnt + BW'(1);
        end
    end

    assign w_blink_off = (r_blink_cnt >= BW'(BLINK_FRAMES)) && blink_mask[r_digit];
`else
    assign w_blink_off = 1'b0;
`endif

    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) r_state <= ST_GAP;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_GAP:  if (w_gap_done)  w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_scan_done) w_state_nxt = ST_GAP;
            default: w_state_nxt = ST_GAP;
        endcase
    end

    // Gap, slice and digit counters; duty is sampled once per slot
    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            r_gap   <= '0;
            r_sub   <= '0;
            r_slice <= 4'd0;
            r_duty  <= 4'd0;
            r_digit <= 2'd0;
        end else if (r_state == ST_GAP) begin
            r_gap <= w_gap_done ? '0 : r_gap + GW'(1);
            if (w_gap_done) begin
                r_duty  <= brightness;
                r_sub   <= '0;
                r_slice <= 4'd0;
            end
        end else begin
            if (w_slice_end) begin
                r_sub   <= '0;
                r_slice <= r_slice + 4'd1;
            end else begin
                r_sub <= r_sub + SW'(1);
            end
            if (w_scan_done) r_digit <= r_digit + 2'd1;
        end
    end

    // Shadow/active frame buffers; commit and transfer are exclusive on wr_ready
    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            r_act_data   <= 16'd0;
            r_act_dp     <= 4'd0;
            r_act_blank  <= 4'd0;
            r_sh_data    <= 16'd0;
            r_sh_dp      <= 4'd0;
            r_sh_blank   <= 4'd0;
            r_wr_ready   <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_tick_nxt;
            if (w_commit && !r_wr_ready) begin
                r_act_data  <= r_sh_data;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_wr_ready  <= 1'b1;
            end
            if (w_xfer) begin
                r_sh_data  <= wr_data;
                r_sh_dp    <= wr_dp;
                r_sh_blank <= wr_blank;
                r_wr_ready <= 1'b0;
            end
        end
    end

    always_comb begin
        w_en_nxt   = 4'b1111;
        w_dt_nxt   = 1'b1;
        w_data_nxt = r_data_seg;
        if (r_state == ST_SCAN) begin
            w_data_nxt = w_nibble;
            if ((r_slice <= r_duty) && !r_act_blank[r_digit] && !w_lz[r_digit] && !w_blink_off) begin
                w_en_nxt = ~(4'b0001 << r_digit);
                w_dt_nxt = ~r_act_dp[r_digit];
            end
        end
    end

    always_ff @(posedge FPGA_CLK or negedge RESET_BUT) begin
        if (!RESET_BUT) begin
            r_en_seg   <= 4'b1111;
            r_dt       <= 1'b1;
            r_data_seg <= 4'd0;
        end else begin
            r_en_seg   <= w_en_nxt;
            r_dt       <= w_dt_nxt;
            r_data_seg <= w_data_nxt;
        end
    end

    assign en_seg     = r_en_seg;
    assign dt         = r_dt;
    assign data_seg   = r_data_seg;
    assign frame_tick = r_frame_tick;
    assign wr_ready   = r_wr_ready;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CYC=32, GAP_CYC=2 (136-cycle frames).
// Cycle k = samples taken on the falling edge after the k-th rising edge since reset release.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp, wr_blank, brightness;
    logic        lz_blank_en;
    logic [3:0]  data_seg, en_seg;
    logic        dt, frame_tick;
`ifdef SEG_BLINK_EN
    logic [3:0]  blink_mask;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;
    int lit[4];

    seg_scan_ctrl #(
        .DWELL_CYC(32),
        .GAP_CYC(2)
`ifdef SEG_BLINK_EN
        ,.BLINK_FRAMES(2)
`endif
    ) dut (
        .FPGA_CLK(clk),
        .RESET_BUT(rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_dp(wr_dp),
        .wr_blank(wr_blank),
        .brightness(brightness),
        .lz_blank_en(lz_blank_en),
        .data_seg(data_seg),
        .en_seg(en_seg),
        .dt(dt),
        .frame_tick(frame_tick)
`ifdef SEG_BLINK_EN
        ,.blink_mask(blink_mask)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] blk);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = dp;
        wr_blank = blk;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    // Lit cycles per digit over the output window of frame f
    task automatic count_frame(input int f);
        goto(136 * f);
        for (int i = 0; i < 4; i++) lit[i] = 0;
        repeat (136) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) if (!en_seg[i]) lit[i]++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = 16'h0;
        wr_dp       = 4'h0;
        wr_blank    = 4'h0;
        brightness  = 4'd15;
        lz_blank_en = 1'b0;
`ifdef SEG_BLINK_EN
        blink_mask  = 4'b0000;
`endif
        #23;
        chk("rst_en",    en_seg, 4'b1111);
        chk("rst_dt",    dt, 1'b1);
        chk("rst_data",  data_seg, 4'h0);
        chk("rst_tick",  frame_tick, 1'b0);
        chk("rst_ready", wr_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0: scan order, slot lengths, frame tick
        goto(1);   chk("f0_k1_en",   en_seg, 4'b1111);
        goto(2);   chk("f0_k2_en",   en_seg, 4'b1111);
        goto(3);   chk("f0_k3_en",   en_seg, 4'b1110);
                   chk("f0_k3_data", data_seg, 4'h0);
                   chk("f0_k3_dt",   dt, 1'b1);
        goto(34);  chk("f0_k34_en",  en_seg, 4'b1110);
        goto(35);  chk("f0_k35_en",  en_seg, 4'b1111);
        goto(36);  chk("f0_k36_en",  en_seg, 4'b1111);
        goto(37);  chk("f0_k37_en",  en_seg, 4'b1101);
        goto(71);  chk("f0_k71_en",  en_seg, 4'b1011);
        goto(105); chk("f0_k105_en", en_seg, 4'b0111);
        goto(134); chk("f0_k134_tick", frame_tick, 1'b0);
        goto(135); chk("f0_k135_tick", frame_tick, 1'b1);
        goto(136); chk("f0_k136_tick", frame_tick, 1'b0);
                   chk("f0_k136_en",   en_seg, 4'b0111);
        goto(137); chk("f0_k137_en",   en_seg, 4'b1111);

        // Frame 1: accepted write, then an ignored one
        goto(150); chk("wr1_ready_pre", wr_ready, 1'b1);
        wr(16'h1A2F, 4'b0100, 4'b0000);
        chk("wr1_ready_post", wr_ready, 1'b0);
        goto(160);
        wr(16'h5555, 4'b1111, 4'b0000);
        chk("wr2_ignored_ready", wr_ready, 1'b0);
        goto(250); chk("f1_no_tear_data", data_seg, 4'h0);
        goto(271); chk("f1_tick", frame_tick, 1'b1);
                   chk("f1_ready_at_tick", wr_ready, 1'b0);
        goto(272); chk("f2_ready_after", wr_ready, 1'b1);

        // Frame 2: committed frame 1A2F, dot on digit 2
        goto(280); chk("f2_d0_en", en_seg, 4'b1110); chk("f2_d0_data", data_seg, 4'hF); chk("f2_d0_dt", dt, 1'b1);
        goto(314); chk("f2_d1_en", en_seg, 4'b1101); chk("f2_d1_data", data_seg, 4'h2); chk("f2_d1_dt", dt, 1'b1);
        goto(348); chk("f2_d2_en", en_seg, 4'b1011); chk("f2_d2_data", data_seg, 4'hA); chk("f2_d2_dt", dt, 1'b0);
        goto(375); chk("f2_gap_dt", dt, 1'b1);
        goto(382); chk("f2_d3_en", en_seg, 4'b0111); chk("f2_d3_data", data_seg, 4'h1); chk("f2_d3_dt", dt, 1'b1);

        // Write in the commit cycle is held for one extra frame
        goto(407); chk("f2_tick", frame_tick, 1'b1);
                   chk("f2_ready_at_tick", wr_ready, 1'b1);
        wr(16'h3C4D, 4'b0000, 4'b0000);
        chk("wr3_ready_post", wr_ready, 1'b0);
        goto(415); chk("f3_d0_old_data", data_seg, 4'hF);
        goto(543); chk("f3_tick", frame_tick, 1'b1);
        goto(544); chk("f4_ready", wr_ready, 1'b1);
        goto(552); chk("f4_d0_en", en_seg, 4'b1110); chk("f4_d0_data", data_seg, 4'hD);

        // Brightness PWM
        brightness = 4'd3;
        count_frame(5);
        for (int i = 0; i < 4; i++) chk($sformatf("b3_lit_d%0d", i), lit[i], 8);
        brightness = 4'd0;
        count_frame(7);
        for (int i = 0; i < 4; i++) chk($sformatf("b0_lit_d%0d", i), lit[i], 2);
        brightness = 4'd15;

        // Leading-zero blanking
        lz_blank_en = 1'b1;
        chk("lz1_ready_pre", wr_ready, 1'b1);
        wr(16'h0050, 4'b0000, 4'b0000);
        count_frame(9);
        chk("lz1_lit_d0", lit[0], 32);
        chk("lz1_lit_d1", lit[1], 32);
        chk("lz1_lit_d2", lit[2], 0);
        chk("lz1_lit_d3", lit[3], 0);
        wr(16'h0000, 4'b0000, 4'b0000);
        count_frame(11);
        chk("lz0_lit_d0", lit[0], 32);
        chk("lz0_lit_d1", lit[1], 0);
        chk("lz0_lit_d2", lit[2], 0);
        chk("lz0_lit_d3", lit[3], 0);

        // Pending write lost on reset mid-scan of digit 2
        chk("rs_ready_pre", wr_ready, 1'b1);
        wr(16'h9999, 4'b1111, 4'b0000);
        chk("rs_ready_pending", wr_ready, 1'b0);
        goto(1642); chk("lz0_d0_en", en_seg, 4'b1110); chk("lz0_d0_data", data_seg, 4'h0);
        lz_blank_en = 1'b0;
        goto(1713); chk("rs_pre_en", en_seg, 4'b1011);
`ifdef SEG_BLINK_EN
        blink_mask = 4'b0001;
`endif
        rst_n = 1'b0;
        #1;
        chk("rs_async_en",    en_seg, 4'b1111);
        chk("rs_async_dt",    dt, 1'b1);
        chk("rs_async_ready", wr_ready, 1'b1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        goto(3);  chk("rs_d0_en", en_seg, 4'b1110); chk("rs_d0_data", data_seg, 4'h0);
                  chk("rs_ready", wr_ready, 1'b1);
        goto(40); chk("rs_d1_en", en_seg, 4'b1101); chk("rs_d1_data", data_seg, 4'h0);

`ifdef SEG_BLINK_EN
        // Blink period of 4 frames: frames 0-1 lit, 2-3 dark
        count_frame(1); chk("blk_f1_d0", lit[0], 32); chk("blk_f1_d1", lit[1], 32);
        count_frame(2); chk("blk_f2_d0", lit[0], 0);  chk("blk_f2_d1", lit[1], 32);
        count_frame(3); chk("blk_f3_d0", lit[0], 0);
        count_frame(4); chk("blk_f4_d0", lit[0], 32);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the 4-digit common-anode seven-segment display. It time-multiplexes one 4-bit hex datapath into sevenseg, one digit at a time, so all four digits can be shown instead of the current fixed 2-digit 25 MHz toggle. Writers load a double-buffered 16-bit frame through a valid/ready handshake. The block adds per-digit dwell timing, an anti-ghosting blank gap, 16-level brightness PWM, per-digit dot/blank masks and leading-zero blanking.

Parameters:
DWELL_CYC, 50000, FPGA_CLK cycles per digit slot (1 ms at 50 MHz); must be a multiple of 16 and at least 32.
GAP_CYC, 500, FPGA_CLK cycles with all digits off between slots; must be at least 1.
BLINK_FRAMES, 250, full scan frames per blink half-period (used only with SEG_BLINK_EN).

Ports:
FPGA_CLK  in  1  system clock, 50 MHz
RESET_BUT  in  1  asynchronous active-low reset
wr_valid  in  1  writer presents a new frame
wr_ready  out  1  shadow buffer free
wr_data  in  16  nibble i = digit i; digit0 is rightmost
wr_dp  in  4  dot request per digit, 1 = dot lit
wr_blank  in  4  force-blank per digit, 1 = off
brightness  in  4  0 = 1/16 duty, 15 = full duty
lz_blank_en  in  1  enable leading-zero blanking
data_seg  out  4  nibble for sevenseg
en_seg  out  4  active-low digit enables; bit i = digit i
dt  out  1  active-low dot
frame_tick  out  1  1-cycle pulse at each frame commit point
blink_mask  in  4  present only with SEG_BLINK_EN

Behaviour:
- Reset (async assert, sync release). Values: en_seg=4'b1111, dt=1, data_seg=0, frame_tick=0, wr_ready=1. Active and shadow buffers are cleared (data 0, dp 0, blank 0). digit_idx=0, state=GAP, counters 0.
- The FSM has two states, GAP and SCAN.
- GAP: en_seg=4'b1111, dt=1. After GAP_CYC cycles, go to SCAN. On entry to SCAN, latch brightness into duty_q and clear dwell_cnt.
- SCAN: runs DWELL_CYC cycles. The slot length is fixed: slice = dwell_cnt / (DWELL_CYC/16).
- Digit on condition, all of the following: slice <= duty_q, not blank[digit_idx], not LZ-blanked.
- When the digit is on: en_seg bit digit_idx = 0, others 1; dt = ~dp[digit_idx].
- When the digit is off: en_seg=4'b1111, dt=1.
- data_seg = active nibble digit_idx throughout SCAN. It is registered, so it changes together with en_seg.
- End of SCAN: digit_idx increments mod 4, then go to GAP. Sequence: 0,1,2,3,0,...
- Frame commit happens on the last SCAN cycle of digit 3:
  - frame_tick=1 for that cycle.
  - If the shadow is full, copy shadow to active, shadow becomes empty, wr_ready returns to 1 on the next cycle.
  - The new frame is first visible on digit 0 of the next frame, so no frame tearing occurs.
- Write handshake:
  - Transfer happens on wr_valid && wr_ready; the shadow captures wr_data, wr_dp and wr_blank.
  - wr_ready goes to 0 on the next cycle and stays 0 until commit.
  - wr_valid while wr_ready=0 is ignored; the writer holds it.
  - Transfer and commit in the same cycle: the commit takes the old shadow contents; the new data stays in the shadow and wr_ready stays 0.
- Leading-zero blanking (evaluated on the active buffer):
  - Digit i (i = 1..3) is blanked when lz_blank_en=1 and nibbles i..3 are all 0.
  - Digit 0 is never LZ-blanked.
  - Blanking is independent of dp; a blanked digit also suppresses its dot.
- brightness changes mid-slot take effect at the next slot. lz_blank_en takes effect immediately (combinational on the registered outputs' next cycle).
- Reset mid-scan: outputs go to reset values immediately, asynchronously. Any pending shadow write is lost.

Optional Feature:
SEG_BLINK_EN
- Defined:
  - blink_mask port exists.
  - A frame counter counts frame_ticks modulo 2*BLINK_FRAMES.
  - During the upper half, digits with blink_mask[i]=1 are forced off (dot included).
  - The counter resets to 0.
- Undefined: no port and no counter; behaviour is otherwise identical.

Test Plan:
All tests use DWELL_CYC=32 and GAP_CYC=2.
- Reset release, no writes, brightness=15 -> en_seg cycles 1110,1111(2 cyc),1101,1111,1011,1111,0111 with 32-cycle slots; data_seg=0; frame_tick every 136 cycles.
- Write 16'h1A2F, wr_dp=4'b0100 mid-frame -> wr_ready=0 next cycle. After the next frame_tick: digits show F,2,A,1; dt=0 only while digit 2 is lit; wr_ready=1.
- Second write while wr_ready=0 -> ignored; active buffer is unchanged after commit. A write coinciding with frame_tick is held and committed one frame later.
- brightness=3 -> each digit is lit exactly 8 of 32 slot cycles (slices 0..3). brightness=0 -> lit 2 cycles.
- lz_blank_en=1, data 16'h0050 -> digits 3 and 2 never enabled, digits 1 and 0 lit. Data 16'h0000 -> only digit 0 lit, showing 0.
- Assert RESET_BUT low mid-SCAN of digit 2 with a pending shadow -> en_seg=1111 and dt=1 immediately. After release: digit 0 shows 0 and wr_ready=1. With SEG_BLINK_EN and BLINK_FRAMES=2, blink_mask=0001 -> digit 0 is dark in frames 2-3 and lit in frames 0-1.
